// File: rtl/mshr_entry_alloc_if.sv
// MSHR entry allocator handshake bundle.
// Grant/free one-hot vectors plus the retire-path dealloc request.
interface mshr_entry_alloc_if #(
    parameter int ENTRY_NUM = 8
);
    localparam int ID_WIDTH = $clog2(ENTRY_NUM);

    logic                 alloc_req_vld;
    logic                 alloc_req_rdy;
    logic [ENTRY_NUM-1:0] alloc_onehot;
    logic [ENTRY_NUM-1:0] free_onehot;
    logic                 dealloc_vld;
    logic [ID_WIDTH-1:0]  dealloc_id;

    modport master (
        output alloc_req_vld,
        output dealloc_vld,
        output dealloc_id,
        input  alloc_req_rdy,
        input  alloc_onehot,
        input  free_onehot
    );

    modport slave (
        input  alloc_req_vld,
        input  dealloc_vld,
        input  dealloc_id,
        output alloc_req_rdy,
        output alloc_onehot,
        output free_onehot
    );
endinterface

// File: rtl/mshr_entry_alloc.sv
// MSHR entry allocator: round-robin free-entry pick, one grant per cycle,
// retire-path dealloc with illegal-release error pulse.
module mshr_entry_alloc #(
    parameter int ENTRY_NUM = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    mshr_entry_alloc_if.slave            bus,
    output logic [ENTRY_NUM-1:0]         entry_valid,
    output logic [$clog2(ENTRY_NUM):0]   used_cnt,
    output logic                         full,
    output logic                         empty,
    output logic                         dealloc_err
);
    localparam int ID_WIDTH = $clog2(ENTRY_NUM);
    localparam int CNT_W    = ID_WIDTH + 1;
    localparam int PAD_N    = 1 << ID_WIDTH;

    logic [ENTRY_NUM-1:0] valid_q, valid_d;
    logic [ENTRY_NUM-1:0] free_oh;
    logic [ENTRY_NUM-1:0] dealloc_oh;
    logic [PAD_N-1:0]     valid_pad;
    logic [ID_WIDTH-1:0]  rr_q, rr_d;
    logic [ID_WIDTH-1:0]  sel;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 found;
    logic                 fire;
    logic                 dealloc_ok;
    int                   idx;

    // Scan from rr_q with explicit wrap so any ENTRY_NUM works.
    always_comb begin
        free_oh = '0;
        sel     = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= ENTRY_NUM) idx = idx - ENTRY_NUM;
            if (!found && !valid_q[idx]) begin
                found        = 1'b1;
                free_oh[idx] = 1'b1;
                sel          = ID_WIDTH'(idx);
            end
        end
    end

    assign bus.free_onehot   = free_oh;
    assign bus.alloc_req_rdy = |free_oh;
    assign fire              = bus.alloc_req_vld & bus.alloc_req_rdy;
    assign bus.alloc_onehot  = fire ? free_oh : '0;

    // Padded view keeps out-of-range ids from indexing past the vector.
    assign valid_pad  = PAD_N'(valid_q);
    assign dealloc_oh = ENTRY_NUM'(1) << bus.dealloc_id;
    assign dealloc_ok = bus.dealloc_vld
                      && (int'(bus.dealloc_id) < ENTRY_NUM)
                      && valid_pad[bus.dealloc_id];

    always_comb begin
        valid_d = valid_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        err_d   = bus.dealloc_vld & ~dealloc_ok;
        if (fire) begin
            valid_d = valid_d | free_oh;
            rr_d    = (sel == ID_WIDTH'(ENTRY_NUM - 1)) ? '0 : sel + 1'b1;
        end
        if (dealloc_ok) valid_d = valid_d & ~dealloc_oh;
        unique case ({fire, dealloc_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign entry_valid = valid_q;
    assign used_cnt    = cnt_q;
    assign dealloc_err = err_q;
    assign full        = (cnt_q == CNT_W'(ENTRY_NUM));
    assign empty       = (cnt_q == '0);

    always @(posedge clk) begin
        if (rst_n) begin
            assert (cnt_q == CNT_W'($countones(valid_q)));
            assert ($onehot0(bus.alloc_onehot));
            assert ((bus.alloc_onehot & valid_q) == '0);
            assert (cnt_q <= CNT_W'(ENTRY_NUM));
        end
    end
endmodule
